bsg_arb_rr_lock: RTL
====================

# bsg_arb_rr_lock

Parametrised arbiter for request-vector fabrics, the successor to the fixed-priority arbiter. It supports both fixed-priority and round-robin selection, a configurable priority direction, an encoded grant tag, and a grant lock for multi-beat transfers. It sits in front of shared resources such as crossbar outputs and shared memory ports: requesters present `reqs_i`, and the block returns one-hot `grants_o`, gated by downstream `ready_i`.

## Interface
- `inputs_p`, default 16: number of requesters, ≥ 1.
- `lo_to_hi_p`, default 0: 1 = index 0 has highest priority and the search runs upward; 0 = index `inputs_p-1` has highest priority and the search runs downward.
- `rr_p`, default 1: 1 = round-robin; 0 = fixed priority, with the pointer frozen at its reset value.
- `lock_p`, default 1: 1 = lock feature present; 0 = `lock_i` ignored and the lock state tied off.
- `tag_width_lp`, derived: `max(1, ceil(log2(inputs_p)))`.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_n_i`  in  1  reset; synchronous, active-low.
- `ready_i`  in  1  downstream can accept a grant this cycle.
- `reqs_i`  in  `inputs_p`  request vector.
- `lock_i`  in  1  hold the current grant on the next cycles.
- `grants_o`  out  `inputs_p`  one-hot grant, or all zero.
- `v_o`  out  1  `|grants_o`.
- `tag_o`  out  `tag_width_lp`  binary index of the granted requester; 0 when `v_o`=0.

## Operation
- State registers:
  - `last_r` (`tag_width_lp`): last granted index.
  - `locked_r` (1).
  - `lock_idx_r` (`tag_width_lp`).
- Reset values (`reset_n_i`=0 at an edge):
  - `locked_r`=0, `lock_idx_r`=0.
  - `last_r`=`inputs_p-1` if `lo_to_hi_p`=1, else 0. The first search therefore starts at the highest-priority index, so the first arbitration after reset matches fixed priority.
- While `reset_n_i`=0, outputs are forced: `grants_o`=0, `v_o`=0, `tag_o`=0.
- Unlocked selection:
  - Find the first set bit of `reqs_i`, starting one position past `last_r` in the search direction and wrapping modulo `inputs_p`.
  - When `rr_p`=0 the search always starts at the highest-priority index.
- Locked selection (`locked_r`=1):
  - Only `lock_idx_r` is eligible.
  - If `reqs_i[lock_idx_r]`=0, then `v_o`=0 and no other requester is granted that cycle.
- Output gating: `grants_o` = selection AND `ready_i`. `ready_i`=0 forces `v_o`=0; state still updates per the rules below.
- Pointer update: if `v_o`=1 then `last_r` <= `tag_o`; otherwise it holds. It never updates when `rr_p`=0.
- Lock FSM, with two states UNLOCKED and LOCKED:
  - UNLOCKED→LOCKED when `lock_p`=1, `v_o`=1 and `lock_i`=1 at the edge; `lock_idx_r` <= `tag_o`.
  - LOCKED→UNLOCKED when `lock_i`=0 or `reqs_i[lock_idx_r]`=0 at the edge. This applies regardless of `ready_i`.
  - LOCKED→LOCKED otherwise, including `ready_i`=0 cycles.
- `inputs_p`=1 degenerates cleanly: `tag_o` is always 0 and `grants_o[0]` = `reqs_i[0]` & `ready_i`.

## Timing
- Grant path is combinational from `reqs_i`, `ready_i` and state: zero-cycle latency. No combinational path from `lock_i` to any output.
- State is visible one cycle after the granting edge: the round-robin rotation and lock take effect on the next cycle's grant.
- Simultaneous release and re-request: a `lock_i`=0 edge returns the block to UNLOCKED, and the next cycle performs a round-robin search past `lock_idx_r`. The locked requester does not win again if any other requester is active.
- Reset mid-lock: `locked_r` clears on that edge, and the first cycle after reset arbitrates exactly as after power-on reset.
- All-zero `reqs_i`: `v_o`=0 and the pointer holds.

## Structure
- Shared package `bsg_arb_pkg`:
  - `tag_width_lp` computation function.
  - Lock state enum (UNLOCKED, LOCKED).
- Sub-module `bsg_arb_rr_lock_pick`: purely combinational. Inputs: `reqs`, start index and direction. Outputs: one-hot vector and tag, built by double-width masked priority encoding that handles wrap-around.
- The top level holds only the registers, lock FSM and `ready_i` gating.

## Test plan
- Reset with `inputs_p`=16, `lo_to_hi_p`=1, `rr_p`=1, `reqs_i`=16'hFFFF, `ready_i`=1: grants 0,1,2,…,15,0 on consecutive cycles with `tag_o` matching. With `lo_to_hi_p`=0: 15,14,…,0.
- `rr_p`=0, `lo_to_hi_p`=0, `reqs_i`=16'h0101 for 4 cycles: `grants_o`=16'h0100 every cycle and `last_r` unchanged.
- `reqs_i`=16'h0011, `ready_i` pattern 1,0,1: grants 16'h0001, then 0 with `v_o`=0, then 16'h0010. No index is skipped.
- Lock on index 4 (`lock_i`=1 for 3 cycles, `reqs_i`=16'h00F0): `grants_o`=16'h0010 for 4 cycles. After `lock_i`=0 the next grant is 16'h0020.
- Locked on index 4 when `reqs_i[4]` drops while `reqs_i`=16'h0020: that cycle `v_o`=0. The next cycle grants 16'h0020 and the block is UNLOCKED.
- `reset_n_i`=0 asserted while LOCKED with `v_o`=1: outputs 0 during reset. After release with `reqs_i`=16'hFFFF and `lo_to_hi_p`=1, the grant is 16'h0001.

Source files
------------

// File: rtl/bsg_arb_pkg.sv
// Shared types and helpers for the bsg_arb round-robin / lock arbiter family.
package bsg_arb_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Width of a binary index into an n-entry request vector; never below 1 bit.
    function automatic int tag_width_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_arb_rr_lock_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface bsg_arb_rr_lock_if
    import bsg_arb_pkg::*;
#(
    parameter int inputs_p = 16
);
    localparam int tag_width_lp = tag_width_f(inputs_p);

    logic                    ready_i;
    logic [inputs_p-1:0]     reqs_i;
    logic                    lock_i;
    logic [inputs_p-1:0]     grants_o;
    logic                    v_o;
    logic [tag_width_lp-1:0] tag_o;

    modport master (
        output ready_i,
        output reqs_i,
        output lock_i,
        input  grants_o,
        input  v_o,
        input  tag_o
    );

    modport slave (
        input  ready_i,
        input  reqs_i,
        input  lock_i,
        output grants_o,
        output v_o,
        output tag_o
    );

endinterface

// File: rtl/bsg_arb_rr_lock_pick.sv
// Combinational circular first-set-bit search from a start index in either direction,
// using a doubled request vector so wrap-around falls out of a plain priority encoder.
module bsg_arb_rr_lock_pick
    import bsg_arb_pkg::*;
#(
    parameter int inputs_p     = 16,
    parameter int tag_width_lp = tag_width_f(inputs_p)
) (
    input  logic [inputs_p-1:0]     reqs_i,
    input  logic [tag_width_lp-1:0] start_i,
    input  logic                    lo_to_hi_i,
    output logic [inputs_p-1:0]     grants_o,
    output logic [tag_width_lp-1:0] tag_o
);
    int                    start_int;
    logic [inputs_p-1:0]   mask;
    logic [2*inputs_p-1:0] dbl;
    int                    hit_idx;
    int                    wrap_idx;
    logic                  hit_v;

    assign start_int = int'(start_i);

    // Mask keeps the portion of the vector searched before the wrap point.
    for (genvar gi = 0; gi < inputs_p; gi++) begin : g_mask
        assign mask[gi] = lo_to_hi_i ? (gi >= start_int) : (gi <= start_int);
    end

    // Upward: masked copy low, full copy high, lowest set bit wins.
    // Downward: masked copy high, full copy low, highest set bit wins.
    assign dbl = lo_to_hi_i ? {reqs_i, reqs_i & mask} : {reqs_i & mask, reqs_i};

    always_comb begin
        hit_idx = -1;
        if (lo_to_hi_i) begin
            for (int i = 2*inputs_p-1; i >= 0; i--) begin
                if (dbl[i]) hit_idx = i;
            end
        end else begin
            for (int i = 0; i < 2*inputs_p; i++) begin
                if (dbl[i]) hit_idx = i;
            end
        end
        hit_v    = (hit_idx >= 0);
        wrap_idx = (hit_idx >= inputs_p) ? hit_idx - inputs_p : hit_idx;
        if (!hit_v) wrap_idx = 0;
        tag_o    = hit_v ? tag_width_lp'(wrap_idx) : '0;
    end

    for (genvar gi = 0; gi < inputs_p; gi++) begin : g_grant
        assign grants_o[gi] = hit_v && (wrap_idx == gi);
    end

endmodule

// File: rtl/bsg_arb_rr_lock.sv
// Round-robin / fixed-priority arbiter with multi-beat grant lock and ready gating.
// Holds the rotation pointer, the lock FSM and the output gating around the picker.
module bsg_arb_rr_lock
    import bsg_arb_pkg::*;
#(
    parameter int inputs_p   = 16,
    parameter int lo_to_hi_p = 0,
    parameter int rr_p       = 1,
    parameter int lock_p     = 1
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bsg_arb_rr_lock_if.slave arb_if
);
    localparam int tag_width_lp = tag_width_f(inputs_p);
    localparam logic [tag_width_lp-1:0] max_idx_lp    = tag_width_lp'(inputs_p-1);
    // Resetting one step "behind" the top-priority index makes the first search fixed-priority.
    localparam logic [tag_width_lp-1:0] last_reset_lp = (lo_to_hi_p != 0) ? max_idx_lp : '0;

    logic [tag_width_lp-1:0] last_q;
    logic [tag_width_lp-1:0] lock_idx_q;
    lock_state_e             state_q;

    logic [tag_width_lp-1:0] start_idx;
    logic [inputs_p-1:0]     pick_grants;
    logic [tag_width_lp-1:0] pick_tag;
    logic [inputs_p-1:0]     lock_onehot;
    logic                    lock_req;
    logic [inputs_p-1:0]     sel_grants;
    logic [tag_width_lp-1:0] sel_tag;
    logic                    out_en;

    always_comb begin
        start_idx = last_q;
        if (lo_to_hi_p != 0) begin
            start_idx = (last_q == max_idx_lp) ? '0 : last_q + 1'b1;
        end else begin
            start_idx = (last_q == '0) ? max_idx_lp : last_q - 1'b1;
        end
    end

    bsg_arb_rr_lock_pick #(
        .inputs_p     (inputs_p),
        .tag_width_lp (tag_width_lp)
    ) u_pick (
        .reqs_i     (arb_if.reqs_i),
        .start_i    (start_idx),
        .lo_to_hi_i (lo_to_hi_p != 0),
        .grants_o   (pick_grants),
        .tag_o      (pick_tag)
    );

    for (genvar gi = 0; gi < inputs_p; gi++) begin : g_lock_onehot
        assign lock_onehot[gi] = (int'(lock_idx_q) == gi);
    end

    assign lock_req = |(arb_if.reqs_i & lock_onehot);

    // While locked nobody but the lock holder may win, even if it stops requesting.
    always_comb begin
        sel_grants = pick_grants;
        sel_tag    = pick_tag;
        if (state_q == LOCKED) begin
            sel_grants = arb_if.reqs_i & lock_onehot;
            sel_tag    = lock_req ? lock_idx_q : '0;
        end
    end

    assign out_en          = reset_n_i & arb_if.ready_i;
    assign arb_if.grants_o = out_en ? sel_grants : '0;
    assign arb_if.v_o      = |arb_if.grants_o;
    assign arb_if.tag_o    = arb_if.v_o ? sel_tag : '0;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            last_q <= last_reset_lp;
        end else if ((rr_p != 0) && arb_if.v_o) begin
            last_q <= arb_if.tag_o;
        end
    end

    if (lock_p != 0) begin : g_lock
        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                state_q    <= UNLOCKED;
                lock_idx_q <= '0;
            end else begin
                case (state_q)
                    UNLOCKED: begin
                        if (arb_if.v_o && arb_if.lock_i) begin
                            state_q    <= LOCKED;
                            lock_idx_q <= arb_if.tag_o;
                        end
                    end
                    LOCKED: begin
                        // Release does not wait for ready: a stalled beat still drops the lock.
                        if (!arb_if.lock_i || !lock_req) begin
                            state_q <= UNLOCKED;
                        end
                    end
                    default: state_q <= UNLOCKED;
                endcase
            end
        end
    end else begin : g_no_lock
        logic unused_lock;
        assign unused_lock = arb_if.lock_i;
        assign state_q     = UNLOCKED;
        assign lock_idx_q  = '0;
    end

endmodule
